fifo_fwft: RTL and testbench
============================

# fifo_fwft

Parametrised synchronous FIFO with first-word-fall-through output. It is the successor to the basic 8-entry FIFO. It uses all DEPTH entries and adds programmable almost-full and almost-empty thresholds, a synchronous flush, sticky overflow and underflow error flags, and a full-width occupancy count. It sits between producer and consumer blocks in one clock domain, for example UART or bus bridges feeding a softcore peripheral.

## Interface
- DATA_WIDTH, 16: entry width in bits.
- DEPTH, 8: number of storage entries; power of two, ≥2; all DEPTH entries are usable.
- AF_THRESH, DEPTH-1: o_almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: o_almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- CW: derived, $clog2(DEPTH+1); width of the count outputs.
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_w_data  in  DATA_WIDTH  write data.
- i_w_stb  in  1  write request.
- i_r_stb  in  1  read/pop request; pops the entry shown on o_r_data.
- i_flush  in  1  synchronous discard of all contents.
- i_clear_err  in  1  clears o_overflow and o_underflow.
- o_r_data  out  DATA_WIDTH  head entry; meaningful only while o_valid=1.
- o_valid  out  1  FIFO non-empty; always equals !o_empty.
- o_empty, o_full  out  1  status flags.
- o_almost_empty, o_almost_full  out  1  threshold flags.
- o_count  out  CW  entries held, 0..DEPTH.
- o_free  out  CW  DEPTH - o_count.
- o_overflow, o_underflow  out  1  sticky error flags.

## Operation
- Pointers are log2(DEPTH)+1 bits wide. The extra MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: pointers are equal except the MSB.
- Read acceptance: rd_ok = i_r_stb & o_valid.
- Write acceptance: wr_ok = i_w_stb & (!o_full | rd_ok).
  - A write to a full FIFO with a simultaneous accepted read is accepted; count is unchanged.
  - A write and read on an empty FIFO: the write is accepted and the read is rejected, so the written word is not popped.
- Count update:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - Both, or neither: unchanged.
- o_count never exceeds DEPTH and never underflows.
- Flags are registered and consistent with the next-state count:
  - o_empty = (count==0); o_full = (count==DEPTH).
  - o_almost_full = (count ≥ AF_THRESH); o_almost_empty = (count ≤ AE_THRESH).
- o_free is computed as DEPTH - o_count at CW bits, with no truncation.
- Errors:
  - o_overflow sets on i_w_stb & !wr_ok.
  - o_underflow sets on i_r_stb & !o_valid.
  - Both are sticky until i_clear_err.
  - If i_clear_err and a new error occur in the same cycle, set wins.
- The data of a rejected write is dropped, and storage is not modified.
- Flush: when i_flush=1, pointers and count go to 0 and the flags take their empty values.
  - Any write or read in the same cycle is ignored.
  - No error flag is set in a flush cycle; existing error flags are retained.
- Priority: reset > flush > read/write.
- Ordering is strict FIFO across pointer wrap-around.

## Timing
- Reset (i_reset_n=0 at an edge) gives:
  - o_count=0, o_free=DEPTH.
  - o_empty=1, o_valid=0, o_full=0.
  - o_almost_empty=1, o_almost_full=0.
  - o_overflow=0, o_underflow=0, o_r_data=0.
- Reset mid-operation discards all contents at that edge.
- Write-to-read latency is 1 cycle. After the edge that accepts a write into an empty FIFO, o_valid=1 and o_r_data holds that word in the same cycle.
- o_r_data is driven from registers or storage only; there is no combinational path from i_w_data.
- Pop: after the edge with rd_ok, o_r_data presents the next entry, or o_valid drops if that was the last one.
- Back-to-back writes and reads are accepted every cycle; throughput is 1 word/cycle in each direction.
- All outputs change only on rising edges.
- Status outputs depend only on state, never combinationally on the current inputs.

## Test plan
All scenarios use DATA_WIDTH=16, DEPTH=4, AF_THRESH=3, AE_THRESH=1.

1. **Fill:** after reset, write 0xA001..0xA004 on 4 consecutive cycles.
   - One cycle after the first write: o_valid=1, o_r_data=0xA001.
   - o_almost_empty drops after the 2nd write; o_almost_full rises after the 3rd.
   - After the 4th: o_full=1, o_count=4, o_free=0.
2. **Full pass-through:** while full, i_w_stb with 0xB000 and i_r_stb in the same cycle.
   - o_count stays 4, o_overflow=0, o_r_data becomes 0xA002.
   - 0xB000 is read out 4th.
3. **Overflow:** while full, write 0xDEAD without a read.
   - o_overflow=1, o_count=4, 0xDEAD is never read out.
   - Pulse i_clear_err: o_overflow=0.
   - i_clear_err together with a new overflow: o_overflow stays 1.
4. **Underflow and empty write+read:** on an empty FIFO, assert i_r_stb alone.
   - o_underflow=1, o_count=0.
   - Then write 0x1234 with i_r_stb in the same cycle: o_count=1, o_r_data=0x1234.
5. **Wrap-around:** 20 cycles of continuous simultaneous push/pop of 0x0000..0x0013 after pre-loading 2 words.
   - Output order exact, o_count constant at 2, no error flags.
6. **Flush and reset:** with 3 entries, assert i_flush together with i_w_stb and i_r_stb.
   - Next cycle: o_count=0, o_empty=1, no error flag change.
   - Refill 2 entries, then drive i_reset_n=0 for one edge: all outputs take their reset values.

Source files
------------

// File: rtl/fifo_fwft_if.sv
// Producer/consumer handshake bundle for fifo_fwft.
// The master side drives the strobes and data; the slave (FIFO) side returns data and status.
interface fifo_fwft_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] i_w_data;
  logic                  i_w_stb;
  logic                  i_r_stb;
  logic                  i_flush;
  logic                  i_clear_err;

  logic [DATA_WIDTH-1:0] o_r_data;
  logic                  o_valid;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_almost_empty;
  logic                  o_almost_full;
  logic [CW-1:0]         o_count;
  logic [CW-1:0]         o_free;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_w_data, i_w_stb, i_r_stb, i_flush, i_clear_err,
    input  o_r_data, o_valid, o_empty, o_full, o_almost_empty, o_almost_full,
           o_count, o_free, o_overflow, o_underflow
  );

  modport slave (
    input  i_w_data, i_w_stb, i_r_stb, i_flush, i_clear_err,
    output o_r_data, o_valid, o_empty, o_full, o_almost_empty, o_almost_full,
           o_count, o_free, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_fwft.sv
// First-word-fall-through synchronous FIFO: head word visible 1 cycle after the write that fills it.
// Writes to a full FIFO are dropped (sticky overflow) unless a pop happens in the same cycle.
module fifo_fwft #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input logic        i_clk,
  input logic        i_reset_n,
  fifo_fwft_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t         mem_q [DEPTH];
  word_t         mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_q, free_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_ok, wr_ok;

  always_comb begin
    rd_ok    = bus.i_r_stb & ~empty_q;
    wr_ok    = bus.i_w_stb & (~full_q | rd_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_ptr_q[AW-1:0]] = bus.i_w_data;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    // Wrap bit distinguishes full (MSBs differ) from empty; the difference is the occupancy.
    count_d = CW'(wr_ptr_d - rd_ptr_d);
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
    free_d  = DEPTH_C - count_d;

    // Set beats clear; a flush cycle never raises a new error.
    ovf_d = (ovf_q & ~bus.i_clear_err) | (~bus.i_flush & bus.i_w_stb & ~wr_ok);
    unf_d = (unf_q & ~bus.i_clear_err) | (~bus.i_flush & bus.i_r_stb & empty_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      free_q   <= DEPTH_C;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      free_q   <= free_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.o_r_data       = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.o_valid        = ~empty_q;
  assign bus.o_empty        = empty_q;
  assign bus.o_full         = full_q;
  assign bus.o_almost_empty = ae_q;
  assign bus.o_almost_full  = af_q;
  assign bus.o_count        = count_q;
  assign bus.o_free         = free_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = unf_q;
endmodule

// File: tb/tb_fifo_fwft.sv
// Scoreboard bench for fifo_fwft (DEPTH=4, AF=3, AE=1): directed scenarios then random traffic.
module tb_fifo_fwft;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_fwft_if #(.DATA_WIDTH(16), .DEPTH(DEPTH)) bus ();

  fifo_fwft #(
    .DATA_WIDTH(16),
    .DEPTH     (DEPTH),
    .AF_THRESH (3),
    .AE_THRESH (1)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          cnt = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // A pop happens on the coming edge: compare the presented word with the oldest accepted write.
  always @(negedge clk) begin
    if (rst_n && !bus.i_flush && bus.i_r_stb && bus.o_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected actual=%0h expected=none", bus.o_r_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.o_r_data !== e) begin
          failures++;
          $display("FAIL pop_data actual=%0h expected=%0h", bus.o_r_data, e);
        end
      end
    end
  end

  task automatic check_status();
    chk("count", bus.o_count, cnt);
    chk("free", bus.o_free, DEPTH - cnt);
    chk("empty", bus.o_empty, cnt == 0);
    chk("valid", bus.o_valid, cnt != 0);
    chk("full", bus.o_full, cnt == DEPTH);
    chk("almost_empty", bus.o_almost_empty, cnt <= 1);
    chk("almost_full", bus.o_almost_full, cnt >= 3);
    chk("overflow", bus.o_overflow, m_ovf);
    chk("underflow", bus.o_underflow, m_unf);
    if (cnt > 0 && exp_q.size() > 0) chk("head", bus.o_r_data, exp_q[0]);
  endtask

  task automatic step(input bit w, input logic [15:0] d, input bit r, input bit fl, input bit ce);
    bit rd, wr;
    bus.i_w_stb     = w;
    bus.i_w_data    = d;
    bus.i_r_stb     = r;
    bus.i_flush     = fl;
    bus.i_clear_err = ce;
    rd = r && (cnt > 0);
    wr = w && ((cnt < DEPTH) || rd);
    if (ce) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (fl) begin
      cnt = 0;
      exp_q.delete();
    end else begin
      if (w && !wr) m_ovf = 1;
      if (r && !rd) m_unf = 1;
      if (wr) exp_q.push_back(d);
      cnt = cnt + int'(wr) - int'(rd);
    end
    @(posedge clk);
    #1;
    bus.i_w_stb     = 1'b0;
    bus.i_r_stb     = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_clear_err = 1'b0;
    check_status();
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.i_w_stb     = 1'b0;
    bus.i_r_stb     = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_clear_err = 1'b0;
    bus.i_w_data    = 16'h5A5A;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt   = 0;
    m_ovf = 0;
    m_unf = 0;
    exp_q.delete();
    chk("reset_r_data", bus.o_r_data, 32'h0);
    check_status();
  endtask

  task automatic wr(input logic [15:0] d);
    step(1, d, 0, 0, 0);
  endtask

  task automatic rd();
    step(0, 16'h0, 1, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_w_stb     = 1'b0;
    bus.i_r_stb     = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_clear_err = 1'b0;
    bus.i_w_data    = '0;
    do_reset();

    // Fill, then full pass-through
    for (int i = 1; i <= 4; i++) wr(16'hA000 + 16'(i));
    step(1, 16'hB000, 1, 0, 0);

    // Overflow, clear, clear colliding with a new overflow
    wr(16'hDEAD);
    step(0, 16'h0, 0, 0, 1);
    step(1, 16'hDEAD, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) rd();

    // Underflow, then write+read on empty
    rd();
    step(1, 16'h1234, 1, 0, 0);
    step(0, 16'h0, 1, 0, 1);

    // Wrap-around with constant occupancy of 2
    wr(16'hC001);
    wr(16'hC002);
    for (int i = 0; i < 20; i++) step(1, 16'(i), 1, 0, 0);
    rd();
    rd();

    // Flush with simultaneous strobes, refill, reset mid-operation
    for (int i = 0; i < 3; i++) wr(16'hE000 + 16'(i));
    rd();
    wr(16'hE003);
    step(1, 16'hFFFF, 1, 1, 0);
    wr(16'hF001);
    wr(16'hF002);
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 50,
             $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
      end
    end
    while (cnt > 0) rd();
    step(0, 16'h0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
